round_iter_counter: RTL and testbench

//   Parametrised round/iteration sequencer for the cipher control FSM. Loads a round count,

---
 rtl/round_ctr_pkg.sv | 20 ++
 rtl/round_iter_counter.sv | 175 +++++++++++++++++
 tb/tb_round_iter_counter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/round_ctr_pkg.sv
// Shared types and helpers for the cipher round/iteration sequencer.
// The state encodings are kept as localparams so other blocks can decode them directly.
package round_ctr_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } round_state_e;

    function automatic logic legal_rounds(input int unsigned value,
                                          input int unsigned max_rounds);
        return (value >= 1) && (value <= max_rounds);
    endfunction

endpackage

// File: rtl/round_iter_counter.sv
// Round/iteration sequencer: loads a round count, steps on advance, and reports the index,
// first/last-round flags, a done pulse and an err pulse for rejected loads.
//
//   state | meaning
//   IDLE  | no sequence; waiting for a legal load
//   RUN   | sequence active; round_idx is the current round
//   DONE  | one cycle after the final advance; done is high
module round_iter_counter
    import round_ctr_pkg::*;
#(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned MAX_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             reverse,
    input  logic             advance,
    input  logic             abort,
    output logic [CNT_W-1:0] round_idx,
    output logic             first_round,
    output logic             last_round,
    output logic             busy,
    output logic             done,
    output logic             err
);

    round_state_e     state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             rev_q, rev_d;
    logic             err_q, err_d;

    logic             load_ok;
    logic             rem_is_one;

    assign load_ok    = legal_rounds(32'(load_value), MAX_ROUNDS);
    assign rem_is_one = (rem_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!abort && load && load_ok) state_d = RUN;
            end
            RUN: begin
                if (abort)                               state_d = IDLE;
                else if (!load && advance && rem_is_one) state_d = DONE;
            end
            DONE: begin
                if (!abort && load && load_ok) state_d = RUN;
                else                           state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A load seen in RUN wins over advance: it is rejected and the step is dropped.
    always_comb begin
        rem_d   = rem_q;
        idx_d   = idx_q;
        first_d = first_q;
        last_d  = last_q;
        rev_d   = rev_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!abort && load) begin
                    if (load_ok) begin
                        rem_d   = load_value;
                        idx_d   = reverse ? (load_value - CNT_W'(1)) : '0;
                        first_d = 1'b1;
                        last_d  = (load_value == CNT_W'(1));
                        rev_d   = reverse;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    rem_d   = '0;
                    idx_d   = '0;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                end else if (load) begin
                    err_d = 1'b1;
                end else if (advance) begin
                    first_d = 1'b0;
                    if (rem_is_one) begin
                        rem_d  = '0;
                        last_d = 1'b0;
                    end else begin
                        rem_d  = rem_q - CNT_W'(1);
                        idx_d  = rev_q ? (idx_q - CNT_W'(1)) : (idx_q + CNT_W'(1));
                        last_d = (rem_q == CNT_W'(2));
                    end
                end
            end
            DONE: begin
                if (!abort && load && load_ok) begin
                    rem_d   = load_value;
                    idx_d   = reverse ? (load_value - CNT_W'(1)) : '0;
                    first_d = 1'b1;
                    last_d  = (load_value == CNT_W'(1));
                    rev_d   = reverse;
                end else begin
                    rem_d   = '0;
                    idx_d   = '0;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                    err_d   = !abort && load;
                end
            end
            default: begin
                rem_d   = '0;
                idx_d   = '0;
                first_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            rev_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            last_q  <= last_d;
            rev_q   <= rev_d;
            err_q   <= err_d;
        end
    end

    assign round_idx   = idx_q;
    assign first_round = first_q;
    assign last_round  = last_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign err         = err_q;

    a_done_after_run: assert property (@(posedge clk) disable iff (rst)
        done |-> ($past(state_q) == RUN));

    a_busy_is_run: assert property (@(posedge clk) disable iff (rst)
        busy == (state_q == RUN));

    a_one_pulse: assert property (@(posedge clk) disable iff (rst)
        !(done && err));

    // Index range follows from remaining: fwd idx+rem == N, rev idx == rem-1.
    a_idx_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == RUN) |-> ((rem_q != '0) &&
                              (rev_q ? (idx_q == rem_q - CNT_W'(1))
                                     : (32'(idx_q) + 32'(rem_q) <= MAX_ROUNDS))));

endmodule

// File: tb/tb_round_iter_counter.sv
// Bench for round_iter_counter: directed scenarios plus random traffic, all checked
// against a sequence-list reference model of the round ordering.
module tb_round_iter_counter;

    localparam int CNT_W = 4;
    localparam int MAXR  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic             reverse;
    logic             advance;
    logic             abort;
    logic [CNT_W-1:0] round_idx;
    logic             first_round;
    logic             last_round;
    logic             busy;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    round_iter_counter #(.CNT_W(CNT_W), .MAX_ROUNDS(MAXR)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .reverse    (reverse),
        .advance    (advance),
        .abort      (abort),
        .round_idx  (round_idx),
        .first_round(first_round),
        .last_round (last_round),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the list of indices the sequence will visit and a cursor into it.
    bit m_run;
    bit m_done;
    bit m_err;
    int m_seq[$];
    int m_pos;
    int m_final;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_pos   = 0;
        m_final = 0;
        m_seq.delete();
    endtask

    task automatic model_step(input bit ld, input int val, input bit rv, input bit adv, input bit ab);
        m_err  = 1'b0;
        m_done = 1'b0;
        if (ab) begin
            m_run = 1'b0;
        end else if (ld && m_run) begin
            m_err = 1'b1;
        end else if (ld) begin
            if (val >= 1 && val <= MAXR) begin
                m_seq.delete();
                for (int k = 0; k < val; k++) m_seq.push_back(rv ? (val - 1 - k) : k);
                m_pos = 0;
                m_run = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else if (adv && m_run) begin
            if (m_pos == m_seq.size() - 1) begin
                m_run   = 1'b0;
                m_done  = 1'b1;
                m_final = m_seq[m_pos];
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int exp_idx;
        exp_idx = m_run ? m_seq[m_pos] : (m_done ? m_final : 0);
        check_val({tag, ".idx"},   32'(round_idx),   exp_idx);
        check_val({tag, ".first"}, 32'(first_round), 32'(m_run && m_pos == 0));
        check_val({tag, ".last"},  32'(last_round),  32'(m_run && m_pos == m_seq.size() - 1));
        check_val({tag, ".busy"},  32'(busy),        32'(m_run));
        check_val({tag, ".done"},  32'(done),        32'(m_done));
        check_val({tag, ".err"},   32'(err),         32'(m_err));
    endtask

    task automatic cycle(input bit ld, input int val, input bit rv, input bit adv, input bit ab,
                         input string tag);
        load       = ld;
        load_value = val[CNT_W-1:0];
        reverse    = rv;
        advance    = adv;
        abort      = ab;
        @(posedge clk);
        model_step(ld, val, rv, adv, ab);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic advance_n(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, tag);
    endtask

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        load_value = '0;
        reverse    = 1'b0;
        advance    = 1'b0;
        abort      = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Forward N=10
        cycle(1'b1, 10, 1'b0, 1'b0, 1'b0, "fwd_load");
        advance_n(10, "fwd_adv");
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, "fwd_idle");

        // Reverse N=10
        cycle(1'b1, 10, 1'b1, 1'b0, 1'b0, "rev_load");
        advance_n(10, "rev_adv");
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, "rev_idle");

        // Illegal loads
        cycle(1'b1, 0,  1'b0, 1'b0, 1'b0, "ill_n0");
        cycle(1'b1, 11, 1'b0, 1'b0, 1'b0, "ill_n11");
        cycle(1'b1, 15, 1'b1, 1'b0, 1'b0, "ill_n15");
        cycle(1'b0, 0,  1'b0, 1'b0, 1'b0, "ill_idle");

        // Abort at idx4 together with advance, then a fresh N=3
        cycle(1'b1, 10, 1'b0, 1'b0, 1'b0, "abt_load");
        advance_n(4, "abt_adv");
        check_val("abt_at_idx4", 32'(round_idx), 32'd4);
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b1, "abt_abort");
        cycle(1'b1, 3, 1'b0, 1'b0, 1'b0, "abt_reload");
        advance_n(3, "abt_adv3");
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, "abt_idle");

        // N=1 and back-to-back load (with advance) in the DONE cycle
        cycle(1'b1, 1, 1'b0, 1'b0, 1'b0, "n1_load");
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, "n1_adv");
        cycle(1'b1, 4, 1'b1, 1'b1, 1'b0, "b2b_load");
        advance_n(4, "b2b_adv");
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, "b2b_idle");

        // Asynchronous reset mid-RUN at idx5
        cycle(1'b1, 8, 1'b0, 1'b0, 1'b0, "ar_load");
        advance_n(5, "ar_adv");
        check_val("ar_at_idx5", 32'(round_idx), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("ar_async");
        @(negedge clk);
        check_outputs("ar_held");
        rst = 1'b0;

        // Load while busy is rejected and leaves the index alone
        cycle(1'b1, 6, 1'b1, 1'b0, 1'b0, "bl_load");
        advance_n(2, "bl_adv");
        cycle(1'b1, 3, 1'b0, 1'b0, 1'b0, "bl_busy_load");
        check_val("bl_idx_kept", 32'(round_idx), 32'd3);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, "bl_abort");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 39) == 0, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
